// File: rtl/tdc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tdc_seq_ctrl
// Brief    : Walks the TDC7200 command ROM, drives a byte-wide SPI master and
//            returns TIME1/CALIB1/CALIB2 after each measurement request.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_seq_ctrl #(
    parameter logic [4:0]  CFG_LAST   = 5'd17,
    parameter logic [4:0]  START_ADDR = 5'd18,
    parameter logic [4:0]  READ_BASE  = 5'd20,
    parameter logic [15:0] TIMEOUT    = 16'd50000,
    parameter logic [2:0]  CS_GAP     = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [5:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic        spi_busy,
    input  logic        spi_new_data,
    input  logic [7:0]  spi_rx,
    output logic        tdc_csn,
    input  logic        tdc_intb,
    input  logic        meas_req,
    output logic        init_done,
    output logic        busy,
    output logic [23:0] time1,
    output logic [23:0] calib1,
    output logic [23:0] calib2,
    output logic        result_valid,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SEND     = 3'd2,
        ST_WAITB    = 3'd3,
        ST_GAP      = 3'd4,
        ST_READY    = 3'd5,
        ST_WAIT_INT = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    localparam logic [1:0]  c_PH_INIT  = 2'd0;
    localparam logic [1:0]  c_PH_START = 2'd1;
    localparam logic [1:0]  c_PH_READ  = 2'd2;
    localparam logic [5:0]  c_CFG_END  = {1'b0, CFG_LAST};
    localparam logic [5:0]  c_START    = {1'b0, START_ADDR};
    localparam logic [5:0]  c_READ     = {1'b0, READ_BASE};
    localparam logic [5:0]  c_ROM_TOP  = 6'd31;
    localparam logic [2:0]  c_GAP_LAST = CS_GAP - 3'd1;
    localparam logic [15:0] c_TO_LAST  = TIMEOUT - 16'd1;

    state_t      r_state;
    logic [1:0]  r_phase;
    logic [1:0]  r_byte_idx;
    logic [1:0]  r_read_idx;
    logic [2:0]  r_gap_cnt;
    logic [15:0] r_wait_cnt;
    logic [23:0] r_sh_time1;
    logic [23:0] r_sh_calib1;
    logic [23:0] r_sh_calib2;

    logic w_is_read;
    logic w_last_byte;

    assign w_is_read   = (r_phase == c_PH_READ);
    assign w_last_byte = (r_byte_idx == (w_is_read ? 2'd3 : 2'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_GAP;
            r_phase      <= c_PH_INIT;
            r_byte_idx   <= 2'd0;
            r_read_idx   <= 2'd0;
            r_gap_cnt    <= 3'd0;
            r_wait_cnt   <= 16'd0;
            r_sh_time1   <= 24'd0;
            r_sh_calib1  <= 24'd0;
            r_sh_calib2  <= 24'd0;
            rom_addr     <= 6'd0;
            spi_start    <= 1'b0;
            spi_tx       <= 8'd0;
            tdc_csn      <= 1'b1;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            time1        <= 24'd0;
            calib1       <= 24'd0;
            calib2       <= 24'd0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            spi_start    <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_byte_idx <= 2'd0;
                    tdc_csn    <= 1'b0;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (!spi_busy) begin
                        spi_start <= 1'b1;
                        spi_tx    <= rom_data;
                        r_state   <= ST_WAITB;
                    end
                end
                ST_WAITB: begin
                    if (spi_new_data) begin
                        // Byte 1 of a read is the command echo; bytes 2..4 carry data MSB first.
                        if (w_is_read && (r_byte_idx != 2'd0)) begin
                            case (r_read_idx)
                                2'd0:    r_sh_time1  <= {r_sh_time1[15:0], spi_rx};
                                2'd1:    r_sh_calib1 <= {r_sh_calib1[15:0], spi_rx};
                                default: r_sh_calib2 <= {r_sh_calib2[15:0], spi_rx};
                            endcase
                        end
                        if (rom_addr < c_ROM_TOP) begin
                            rom_addr <= rom_addr + 6'd1;
                        end
                        if (w_last_byte) begin
                            tdc_csn   <= 1'b1;
                            r_gap_cnt <= 3'd0;
                            r_state   <= ST_GAP;
                            if (w_is_read) begin
                                r_read_idx <= r_read_idx + 2'd1;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        case (r_phase)
                            c_PH_INIT: begin
                                if (rom_addr > c_CFG_END) begin
                                    init_done <= 1'b1;
                                    rom_addr  <= c_START;
                                    r_state   <= ST_READY;
                                end else begin
                                    r_state <= ST_INIT;
                                end
                            end
                            c_PH_START: begin
                                r_wait_cnt <= 16'd0;
                                r_state    <= ST_WAIT_INT;
                            end
                            default: begin
                                if (r_read_idx == 2'd3) begin
                                    r_state <= ST_DONE;
                                end else begin
                                    r_byte_idx <= 2'd0;
                                    tdc_csn    <= 1'b0;
                                    r_state    <= ST_FETCH;
                                end
                            end
                        endcase
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 3'd1;
                    end
                end
                ST_READY: begin
                    if (meas_req) begin
                        busy       <= 1'b1;
                        r_phase    <= c_PH_START;
                        r_byte_idx <= 2'd0;
                        tdc_csn    <= 1'b0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_WAIT_INT: begin
                    // INTB is tested first so it wins over a coincident terminal count.
                    if (!tdc_intb) begin
                        r_phase    <= c_PH_READ;
                        r_read_idx <= 2'd0;
                        r_byte_idx <= 2'd0;
                        rom_addr   <= c_READ;
                        tdc_csn    <= 1'b0;
                        r_state    <= ST_FETCH;
                    end else if (r_wait_cnt == c_TO_LAST) begin
                        timeout  <= 1'b1;
                        busy     <= 1'b0;
                        rom_addr <= c_START;
                        r_state  <= ST_READY;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    time1        <= r_sh_time1;
                    calib1       <= r_sh_calib1;
                    calib2       <= r_sh_calib2;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    rom_addr     <= c_START;
                    r_state      <= ST_READY;
                end
                default: begin
                    r_state <= ST_GAP;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_seq_ctrl
// Brief    : Directed + randomized bench for tdc_seq_ctrl with ROM/SPI models
//            and a frame-level reference of the expected TDC traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_seq_ctrl;

    localparam logic [15:0] c_TIMEOUT = 16'd2000;
    localparam logic [2:0]  c_CS_GAP  = 3'd4;
    localparam logic [7:0]  c_CFG_BYTES [18] = '{
        8'h41, 8'h40, 8'h42, 8'h00, 8'h43, 8'h07, 8'h44, 8'h01, 8'h45,
        8'h8F, 8'h46, 8'hFF, 8'h47, 8'hFF, 8'h48, 8'h00, 8'h49, 8'h00};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        spi_start;
    logic [7:0]  spi_tx;
    logic        spi_busy = 1'b0;
    logic        spi_new_data = 1'b0;
    logic [7:0]  spi_rx = 8'd0;
    logic        tdc_csn;
    logic        tdc_intb = 1'b1;
    logic        meas_req = 1'b0;
    logic        init_done;
    logic        busy;
    logic [23:0] time1;
    logic [23:0] calib1;
    logic [23:0] calib2;
    logic        result_valid;
    logic        timeout;

    tdc_seq_ctrl #(
        .CFG_LAST  (5'd17),
        .START_ADDR(5'd18),
        .READ_BASE (5'd20),
        .TIMEOUT   (c_TIMEOUT),
        .CS_GAP    (c_CS_GAP)
    ) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_busy(spi_busy),
        .spi_new_data(spi_new_data), .spi_rx(spi_rx), .tdc_csn(tdc_csn),
        .tdc_intb(tdc_intb), .meas_req(meas_req), .init_done(init_done),
        .busy(busy), .time1(time1), .calib1(calib1), .calib2(calib2),
        .result_valid(result_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  rom [64];
    logic [31:0] fr_q[$];
    int          fr_len_q[$];
    int          rd_ptr = 0;
    logic [31:0] cur_fr = 32'd0;
    int          cur_len = 0;
    int          mdl_cnt = 0;
    logic        ext_busy = 1'b0;
    logic [7:0]  mdl_resp = 8'd0;
    logic [23:0] rd_plan [3];
    logic [23:0] exp_t1 = 24'd0;
    logic [23:0] exp_c1 = 24'd0;
    logic [23:0] exp_c2 = 24'd0;
    int          bad_start = 0;
    int          bad_cs = 0;
    int          partial_err = 0;
    int          rv_count = 0;
    int          to_count = 0;
    int          n_meas = 0;
    int          hi_cnt = 0;
    int          min_gap = 1000;
    int          to_n = 0;
    logic        to_csn = 1'b0;
    logic        to_busy = 1'b1;
    logic        prev_csn = 1'b1;
    logic [71:0] prev_res = 72'd0;
    logic [23:0] snap_t1 = 24'd0;
    logic [23:0] snap_c1 = 24'd0;
    logic [23:0] snap_c2 = 24'd0;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // Response for the byte about to be sent: read frames return the planned words MSB first.
    function automatic logic [7:0] resp_for(input logic [31:0] fr, input int len);
        int k;
        k = -1;
        if (len >= 1) begin
            case (fr[31:24])
                8'h10:   k = 0;
                8'h1B:   k = 1;
                8'h1C:   k = 2;
                default: k = -1;
            endcase
        end
        if (k >= 0 && len <= 3) return rd_plan[k][8*(3-len) +: 8];
        return 8'($urandom);
    endfunction

    // SPI master model, frame recorder and output monitors.
    always @(negedge clk) begin
        spi_new_data = 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) begin
                spi_new_data = 1'b1;
                spi_rx = mdl_resp;
            end
        end
        if (spi_start) begin
            if (spi_busy) bad_start++;
            if (tdc_csn) bad_cs++;
            mdl_resp = resp_for(cur_fr, cur_len);
            if (cur_len < 4) begin
                cur_fr[31-8*cur_len -: 8] = spi_tx;
                cur_len++;
            end
            mdl_cnt = int'($urandom_range(12, 6));
        end
        spi_busy = (mdl_cnt > 0) || ext_busy;

        if (tdc_csn && !prev_csn) begin
            if (cur_len > 0) begin
                fr_q.push_back(cur_fr);
                fr_len_q.push_back(cur_len);
            end
            cur_fr = 32'd0;
            cur_len = 0;
            hi_cnt = 0;
        end else if (tdc_csn) begin
            hi_cnt++;
        end
        if (!tdc_csn && prev_csn && (hi_cnt + 1 < min_gap)) min_gap = hi_cnt + 1;
        prev_csn = tdc_csn;

        if (result_valid) begin
            rv_count++;
            snap_t1 = time1;
            snap_c1 = calib1;
            snap_c2 = calib2;
        end
        if (timeout) begin
            to_count++;
            to_n = hi_cnt;
            to_csn = tdc_csn;
            to_busy = busy;
        end
        if (!rst && !result_valid && ({time1, calib1, calib2} != prev_res)) partial_err++;
        prev_res = {time1, calib1, calib2};
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [31:0] exp, input int len);
        int t;
        t = 0;
        while (fr_q.size() <= rd_ptr && t < 3000) begin
            tick();
            t++;
        end
        if (fr_q.size() <= rd_ptr) begin
            check({tag, "_frame_wait"}, 32'(fr_q.size()), 32'(rd_ptr + 1));
        end else begin
            check({tag, "_bytes"}, fr_q[rd_ptr], exp);
            check({tag, "_len"}, 32'(fr_len_q[rd_ptr]), 32'(len));
            rd_ptr++;
        end
    endtask

    task automatic expect_init_frames(input string tag);
        for (int i = 0; i < 9; i++) begin
            expect_frame($sformatf("%s_cfg%0d", tag, i),
                         {c_CFG_BYTES[2*i], c_CFG_BYTES[2*i+1], 16'h0000}, 2);
        end
    endtask

    task automatic run_meas(input string tag, input bit hold_busy, input bit poke, input int intb_dly);
        int rv0;
        int t;
        rv0 = rv_count;
        if (hold_busy) ext_busy = 1'b1;
        meas_req = 1'b1;
        tick();
        meas_req = 1'b0;
        check({tag, "_busy_set"}, 32'(busy), 32'd1);
        if (hold_busy) begin
            repeat (10) tick();
            check({tag, "_held_no_byte"}, 32'(cur_len), 32'd0);
            ext_busy = 1'b0;
        end
        expect_frame({tag, "_start"}, 32'h4081_0000, 2);
        for (int i = 0; i < intb_dly; i++) begin
            meas_req = (poke && i == intb_dly / 2);
            tick();
        end
        meas_req = 1'b0;
        tdc_intb = 1'b0;
        expect_frame({tag, "_rd_time1"}, 32'h1000_0000, 4);
        expect_frame({tag, "_rd_calib1"}, 32'h1B00_0000, 4);
        expect_frame({tag, "_rd_calib2"}, 32'h1C00_0000, 4);
        t = 0;
        while (rv_count == rv0 && t < 500) begin
            tick();
            t++;
        end
        tdc_intb = 1'b1;
        check({tag, "_result_valid_pulses"}, 32'(rv_count), 32'(rv0 + 1));
        exp_t1 = rd_plan[0];
        exp_c1 = rd_plan[1];
        exp_c2 = rd_plan[2];
        n_meas++;
        check({tag, "_time1"}, 32'(snap_t1), 32'(exp_t1));
        check({tag, "_calib1"}, 32'(snap_c1), 32'(exp_c1));
        check({tag, "_calib2"}, 32'(snap_c2), 32'(exp_c2));
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
        check({tag, "_rom_addr_reload"}, 32'(rom_addr), 32'd18);
    endtask

    initial begin
        int t;
        int to0;
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        for (int i = 0; i < 18; i++) rom[i] = c_CFG_BYTES[i];
        rom[18] = 8'h40;
        rom[19] = 8'h81;
        rom[20] = 8'h10;
        rom[24] = 8'h1B;
        rom[28] = 8'h1C;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_spi_tx", 32'(spi_tx), 32'd0);
        check("rst_csn", 32'(tdc_csn), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_results", 32'(time1 | calib1 | calib2), 32'd0);
        check("rst_pulses", 32'({result_valid, timeout}), 32'd0);

        // Config block, with requests that must be ignored during init
        rst = 1'b0;
        t = 0;
        while (!init_done && t < 6000) begin
            meas_req = (t % 40 == 20);
            tick();
            t++;
        end
        meas_req = 1'b0;
        check("init_done", 32'(init_done), 32'd1);
        check("init_rom_addr", 32'(rom_addr), 32'd18);
        expect_init_frames("init");
        repeat (60) tick();
        check("init_req_ignored_frames", 32'(fr_q.size()), 32'(rd_ptr));
        check("init_req_ignored_busy", 32'(busy), 32'd0);

        // Directed measurement with SPI held busy and a request during busy
        rd_plan[0] = 24'h123456;
        rd_plan[1] = 24'h000ABC;
        rd_plan[2] = 24'h0186A0;
        run_meas("m0", 1'b1, 1'b1, 200);
        repeat (60) tick();
        check("m0_no_queued_req", 32'(fr_q.size()), 32'(rd_ptr));

        // Randomized measurements
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) rd_plan[j] = 24'($urandom);
            run_meas($sformatf("rnd%0d", k), 1'b0, 1'b0, int'($urandom_range(300, 5)));
            repeat (int'($urandom_range(20, 1))) tick();
        end

        // INTB never arrives
        to0 = to_count;
        meas_req = 1'b1;
        tick();
        meas_req = 1'b0;
        expect_frame("to_start", 32'h4081_0000, 2);
        t = 0;
        while (to_count == to0 && t < int'(c_TIMEOUT) + 200) begin
            tick();
            t++;
        end
        check("to_pulse_count", 32'(to_count), 32'(to0 + 1));
        check("to_latency_window", 32'((to_n >= int'(c_TIMEOUT)) &&
              (to_n <= int'(c_TIMEOUT) + int'(c_CS_GAP) + 2)), 32'd1);
        check("to_csn_high", 32'(to_csn), 32'd1);
        check("to_busy_clear", 32'(to_busy), 32'd0);
        check("to_time1_kept", 32'(time1), 32'(exp_t1));
        check("to_calib1_kept", 32'(calib1), 32'(exp_c1));
        check("to_calib2_kept", 32'(calib2), 32'(exp_c2));
        repeat (40) tick();
        check("to_no_reads", 32'(fr_q.size()), 32'(rd_ptr));

        // Request after timeout is accepted
        for (int j = 0; j < 3; j++) rd_plan[j] = 24'($urandom);
        run_meas("after_to", 1'b0, 1'b0, 50);

        // Reset during the second byte of the CALIB1 read
        for (int j = 0; j < 3; j++) rd_plan[j] = 24'($urandom);
        meas_req = 1'b1;
        tick();
        meas_req = 1'b0;
        expect_frame("mr_start", 32'h4081_0000, 2);
        tdc_intb = 1'b0;
        expect_frame("mr_rd_time1", 32'h1000_0000, 4);
        t = 0;
        while (!(cur_len == 2 && cur_fr[31:24] == 8'h1B) && t < 500) begin
            tick();
            t++;
        end
        check("mr_reached_calib1_b2", 32'(cur_len), 32'd2);
        rst = 1'b1;
        #1;
        check("mr_csn_async", 32'(tdc_csn), 32'd1);
        check("mr_init_done", 32'(init_done), 32'd0);
        check("mr_time1_cleared", 32'(time1), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        tdc_intb = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        expect_frame("mr_partial", 32'h1B00_0000, 2);
        expect_init_frames("reinit");
        t = 0;
        while (!init_done && t < 3000) begin
            tick();
            t++;
        end
        check("reinit_done", 32'(init_done), 32'd1);
        check("reinit_time1", 32'(time1), 32'd0);

        // Whole-run invariants
        check("start_while_spi_busy", 32'(bad_start), 32'd0);
        check("start_with_csn_high", 32'(bad_cs), 32'd0);
        check("partial_results_exposed", 32'(partial_err), 32'd0);
        check("cs_gap_min_ok", 32'(min_gap >= int'(c_CS_GAP)), 32'd1);
        check("result_valid_total", 32'(rv_count), 32'(n_meas));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
